// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired CPU control unit: opcodes, FSM state
// encoding, instruction classes, ALU operation codes and the control-word
// struct that bundles every datapath enable.
package cpu_ctrl_pkg;

  // Opcodes, taken from ir[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALTED
  } state_e;

  // Instruction classes; undefined opcodes fold into CLS_NOP
  typedef enum logic [3:0] {
    CLS_ALU, CLS_ADDI, CLS_LDI, CLS_LD, CLS_ST, CLS_BR,
    CLS_IN, CLS_OUT, CLS_NOP, CLS_HALT
  } cls_e;

  typedef struct packed {
    logic pci, pco, iri, mari, mdri, mdro, ryi, rzli, rzlo, gra, grb, grc;
    logic rin, rout, baout, csigno, opi, ipo, conin, incpc, mem_read, mem_write;
  } ctrl_t;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode decoder.
//   opcode : ir[31:27]
//   cls    : instruction class driving the control sequence
//   alu_op : ALU operation for register-register ALU instructions (ADD otherwise)
module opcode_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output cls_e       cls,
  output logic [3:0] alu_op
);

  always_comb begin
    cls    = CLS_NOP;
    alu_op = ALU_ADD;
    case (opcode)
      OP_LD:   cls = CLS_LD;
      OP_LDI:  cls = CLS_LDI;
      OP_ST:   cls = CLS_ST;
      OP_ADD:  begin cls = CLS_ALU; alu_op = ALU_ADD; end
      OP_SUB:  begin cls = CLS_ALU; alu_op = ALU_SUB; end
      OP_AND:  begin cls = CLS_ALU; alu_op = ALU_AND; end
      OP_OR:   begin cls = CLS_ALU; alu_op = ALU_OR;  end
      OP_ADDI: cls = CLS_ADDI;
      OP_BR:   cls = CLS_BR;
      OP_IN:   cls = CLS_IN;
      OP_OUT:  cls = CLS_OUT;
      OP_HALT: cls = CLS_HALT;
      default: cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit for a simple load/store CPU.
//   clock, clear     : rising-edge clock, synchronous active-high reset
//   ir               : instruction register (opcode in ir[31:27])
//   con_ff           : branch condition, gates pci in the BR T6 step
//   stop             : halt request, honoured only when an instruction ends
//   pci..mem_write   : one-bit datapath enables, 0 unless asserted by a step
//   alu_op           : ALU operation, ADD unless an ALU instruction is in T4
//   run              : 1 in T0..T7, 0 in RST and HALTED
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic        pci, pco, iri, mari, mdri, mdro, ryi, rzli, rzlo,
  output logic        gra, grb, grc, rin, rout, baout, csigno, opi, ipo,
  output logic        conin, incpc, mem_read, mem_write,
  output logic [3:0]  alu_op,
  output logic        run
);

  state_e     state_q, state_d;
  cls_e       cls;
  logic [3:0] dec_alu;
  ctrl_t      ctrl;
  state_e     end_state;

  // Only the opcode field steers sequencing; the rest belongs to the datapath.
  logic unused_ir;
  assign unused_ir = ^ir[26:0];

  opcode_decode u_dec (
    .opcode (ir[31:27]),
    .cls    (cls),
    .alu_op (dec_alu)
  );

  // Where an instruction goes when it finishes: stop is looked at only here.
  assign end_state = stop ? ST_HALTED : ST_T0;

  always_ff @(posedge clock) begin
    if (clear) state_q <= ST_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST: state_d = ST_T0;
      ST_T0:  state_d = ST_T1;
      ST_T1:  state_d = ST_T2;
      ST_T2:  state_d = (cls == CLS_NOP) ? end_state : ST_T3;
      ST_T3: begin
        case (cls)
          CLS_HALT:         state_d = ST_HALTED;
          CLS_IN, CLS_OUT:  state_d = end_state;
          default:          state_d = ST_T4;
        endcase
      end
      ST_T4:  state_d = ST_T5;
      ST_T5:  state_d = (cls inside {CLS_ALU, CLS_ADDI, CLS_LDI}) ? end_state : ST_T6;
      ST_T6:  state_d = (cls == CLS_BR) ? end_state : ST_T7;
      ST_T7:  state_d = end_state;
      ST_HALTED: state_d = ST_HALTED;
      default: state_d = ST_RST;
    endcase
  end

  always_comb begin
    ctrl   = '0;
    alu_op = ALU_ADD;
    run    = !(state_q inside {ST_RST, ST_HALTED});
    case (state_q)
      ST_T0: begin ctrl.pco = 1'b1; ctrl.mari = 1'b1; ctrl.incpc = 1'b1; ctrl.rzli = 1'b1; end
      ST_T1: begin ctrl.rzlo = 1'b1; ctrl.pci = 1'b1; ctrl.mem_read = 1'b1; ctrl.mdri = 1'b1; end
      ST_T2: begin ctrl.mdro = 1'b1; ctrl.iri = 1'b1; end
      ST_T3: begin
        case (cls)
          CLS_ALU, CLS_ADDI:        begin ctrl.grb = 1'b1; ctrl.rout = 1'b1;  ctrl.ryi = 1'b1; end
          CLS_LDI, CLS_LD, CLS_ST:  begin ctrl.grb = 1'b1; ctrl.baout = 1'b1; ctrl.ryi = 1'b1; end
          CLS_BR:  begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.conin = 1'b1; end
          CLS_IN:  begin ctrl.ipo = 1'b1; ctrl.gra = 1'b1;  ctrl.rin = 1'b1;   end
          CLS_OUT: begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.opi = 1'b1;   end
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls)
          CLS_ALU: begin ctrl.grc = 1'b1; ctrl.rout = 1'b1; ctrl.rzli = 1'b1; alu_op = dec_alu; end
          CLS_ADDI, CLS_LDI, CLS_LD, CLS_ST: begin ctrl.csigno = 1'b1; ctrl.rzli = 1'b1; end
          CLS_BR:  begin ctrl.pco = 1'b1; ctrl.ryi = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (cls)
          CLS_ALU, CLS_ADDI, CLS_LDI: begin ctrl.rzlo = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
          CLS_LD, CLS_ST: begin ctrl.rzlo = 1'b1; ctrl.mari = 1'b1; end
          CLS_BR:         begin ctrl.csigno = 1'b1; ctrl.rzli = 1'b1; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (cls)
          CLS_LD: begin ctrl.mem_read = 1'b1; ctrl.mdri = 1'b1; end
          CLS_ST: begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.mdri = 1'b1; end
          // PC is loaded with the branch target only when the condition held.
          CLS_BR: begin ctrl.rzlo = 1'b1; ctrl.pci = con_ff; end
          default: ;
        endcase
      end
      ST_T7: begin
        case (cls)
          CLS_LD: begin ctrl.mdro = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
          CLS_ST: ctrl.mem_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign {pci, pco, iri, mari, mdri, mdro, ryi, rzli, rzlo, gra, grb, grc,
          rin, rout, baout, csigno, opi, ipo, conin, incpc, mem_read, mem_write} = ctrl;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear, con_ff, stop;
  logic [31:0] ir;
  logic pci, pco, iri, mari, mdri, mdro, ryi, rzli, rzlo, gra, grb, grc;
  logic rin, rout, baout, csigno, opi, ipo, conin, incpc, mem_read, mem_write;
  logic [3:0]  alu_op;
  logic        run;

  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .stop(stop),
    .pci(pci), .pco(pco), .iri(iri), .mari(mari), .mdri(mdri), .mdro(mdro),
    .ryi(ryi), .rzli(rzli), .rzlo(rzlo), .gra(gra), .grb(grb), .grc(grc),
    .rin(rin), .rout(rout), .baout(baout), .csigno(csigno), .opi(opi), .ipo(ipo),
    .conin(conin), .incpc(incpc), .mem_read(mem_read), .mem_write(mem_write),
    .alu_op(alu_op), .run(run)
  );

  always #5 clock = ~clock;

  // Observed word: {run, alu_op, pci .. mem_write}
  logic [26:0] obs;
  assign obs = {run, alu_op, pci, pco, iri, mari, mdri, mdro, ryi, rzli, rzlo,
                gra, grb, grc, rin, rout, baout, csigno, opi, ipo, conin, incpc,
                mem_read, mem_write};

  localparam logic [26:0] WR  = 27'(1) << 0,  RD   = 27'(1) << 1,  INC  = 27'(1) << 2;
  localparam logic [26:0] CON = 27'(1) << 3,  IPO  = 27'(1) << 4,  OPI  = 27'(1) << 5;
  localparam logic [26:0] CSG = 27'(1) << 6,  BAO  = 27'(1) << 7,  ROUT = 27'(1) << 8;
  localparam logic [26:0] RIN = 27'(1) << 9,  GRC  = 27'(1) << 10, GRB  = 27'(1) << 11;
  localparam logic [26:0] GRA = 27'(1) << 12, RZLO = 27'(1) << 13, RZLI = 27'(1) << 14;
  localparam logic [26:0] RYI = 27'(1) << 15, MDRO = 27'(1) << 16, MDRI = 27'(1) << 17;
  localparam logic [26:0] MARI = 27'(1) << 18, IRI = 27'(1) << 19, PCO  = 27'(1) << 20;
  localparam logic [26:0] PCI = 27'(1) << 21, RUN  = 27'(1) << 26;

  function automatic logic [26:0] aop(input int n);
    return 27'(n) << 22;
  endfunction

  typedef struct { logic [26:0] v; string tag; } exp_t;
  exp_t exp_q[$];
  int checks = 0, passes = 0;

  // Monitor: one expected word per cycle, compared mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.v)
        $display("FAIL %s: got %h expected %h", e.tag, obs, e.v);
      else
        passes++;
    end
  end

  task automatic step(input logic [26:0] v, input string tag);
    exp_t e;
    e.v = v; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clock); #1;
  endtask

  task automatic fetch(input string tag);
    step(RUN|PCO|MARI|INC|RZLI, {tag, " T0"});
    step(RUN|RZLO|PCI|RD|MDRI,  {tag, " T1"});
    step(RUN|MDRO|IRI,          {tag, " T2"});
  endtask

  task automatic alu3(input logic [31:0] i, input int op, input string tag);
    ir = i;
    fetch(tag);
    step(RUN|GRB|ROUT|RYI,              {tag, " T3"});
    step(RUN|GRC|ROUT|RZLI|aop(op),     {tag, " T4"});
    step(RUN|RZLO|GRA|RIN,              {tag, " T5"});
  endtask

  task automatic ld_head(input logic [31:0] i, input string tag);
    ir = i;
    fetch(tag);
    step(RUN|GRB|BAO|RYI, {tag, " T3"});
    step(RUN|CSG|RZLI,    {tag, " T4"});
  endtask

  task automatic br(input logic cf, input string tag);
    ir = 32'h90000000; con_ff = cf;
    fetch(tag);
    step(RUN|GRA|ROUT|CON, {tag, " T3"});
    step(RUN|PCO|RYI,      {tag, " T4"});
    step(RUN|CSG|RZLI,     {tag, " T5"});
    step(RUN|RZLO|(cf ? PCI : 27'd0), {tag, " T6"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1; con_ff = 1'b0; stop = 1'b0; ir = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    step(27'd0, "reset RST");
    clear = 1'b0;
    step(27'd0, "reset RST held");
    // The clear drop above is sampled at the next edge -> T0.
    alu3(32'h18918000, 0, "add");
    ld_head(32'h00800055, "ld");          // T0 here is clock 7 after release
    step(RUN|RZLO|MARI, "ld T5");
    step(RUN|RD|MDRI,   "ld T6");
    step(RUN|MDRO|GRA|RIN, "ld T7");
    br(1'b1, "br taken");
    br(1'b0, "br not taken");
    alu3(32'h20000000, 1, "sub");
    alu3(32'h28000000, 2, "and");
    alu3(32'h30000000, 3, "or");
    ir = 32'h60000000; fetch("addi");
    step(RUN|GRB|ROUT|RYI, "addi T3");
    step(RUN|CSG|RZLI,     "addi T4");
    step(RUN|RZLO|GRA|RIN, "addi T5");
    ir = 32'h08000000; fetch("ldi");
    step(RUN|GRB|BAO|RYI,  "ldi T3");
    step(RUN|CSG|RZLI,     "ldi T4");
    step(RUN|RZLO|GRA|RIN, "ldi T5");
    // stop pulse during IN T1 is ignored
    ir = 32'hB0000000;
    step(RUN|PCO|MARI|INC|RZLI, "in T0");
    stop = 1'b1;
    step(RUN|RZLO|PCI|RD|MDRI,  "in T1");
    stop = 1'b0;
    step(RUN|MDRO|IRI,          "in T2");
    step(RUN|IPO|GRA|RIN,       "in T3");
    ir = 32'hB8000000; fetch("out");
    step(RUN|GRA|ROUT|OPI, "out T3");
    ir = 32'hD0000000; fetch("nop");
    ir = 32'hF8000000; fetch("undef");
    // clear during LD T6
    ld_head(32'h00800055, "ld2");
    step(RUN|RZLO|MARI, "ld2 T5");
    clear = 1'b1;
    step(RUN|RD|MDRI,   "ld2 T6");
    clear = 1'b0;
    step(27'd0, "clear RST");
    // ST with stop raised in T5 and held: finishes, then halts
    ld_head(32'h10000000, "st");
    stop = 1'b1;
    step(RUN|RZLO|MARI,      "st T5");
    step(RUN|GRA|ROUT|MDRI,  "st T6");
    step(RUN|WR,             "st T7");
    step(27'd0, "halted 1");
    stop = 1'b0;
    step(27'd0, "halted 2");
    step(27'd0, "halted 3");
    clear = 1'b1;
    step(27'd0, "halted clear");
    clear = 1'b0;
    step(27'd0, "recover RST");
    ir = 32'hD8000000; fetch("halt");
    step(RUN, "halt T3");
    step(27'd0, "halt HALTED");
    step(27'd0, "halt HALTED 2");
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clock, input, 1 bit: sole clock, rising edge.
REQ-002 SHALL have port clear, input, 1 bit: synchronous active-high reset.
REQ-003 SHALL have port ir, input, 32 bits: instruction register contents from datapath; opcode = ir[31:27].
REQ-004 SHALL have port con_ff, input, 1 bit: branch-condition result from datapath.
REQ-005 SHALL have port stop, input, 1 bit: request halt at next instruction boundary.
REQ-006 SHALL have ports pci pco iri mari mdri mdro ryi rzli rzlo gra grb grc rin rout baout csigno opi ipo conin incpc mem_read mem_write, each output, 1 bit: datapath enables/selects, each default 0.
REQ-007 SHALL have port alu_op, output, 4 bits: ALU operation, default ADD.
REQ-008 SHALL have port run, output, 1 bit: 1 while executing, 0 when halted.

Function
REQ-009 SHALL be a Moore FSM; outputs are a combinational function of state and ir only; every signal not listed for a state is 0.
REQ-010 SHALL run fetch in all instructions: T0 pco mari incpc rzli; T1 rzlo pci mem_read mdri; T2 mdro iri.
REQ-011 SHALL decode ir[31:27] in T3 (ir valid from end of T2).
REQ-012 SHALL use opcodes LD 00000, LDI 00001, ST 00010, ADD 00011, SUB 00100, AND 00101, OR 00110, ADDI 01100, BR 10010, IN 10110, OUT 10111, NOP 11010, HALT 11011.
REQ-013 SHALL execute ADD/SUB/AND/OR as T3 grb rout ryi; T4 grc rout rzli, alu_op per opcode; T5 rzlo gra rin; then T0.
REQ-014 SHALL execute ADDI as T3 grb rout ryi; T4 csigno rzli, alu_op ADD; T5 rzlo gra rin.
REQ-015 SHALL execute LDI as ADDI except T3 uses baout in place of rout.
REQ-016 SHALL execute LD as T3 grb baout ryi; T4 csigno rzli ADD; T5 rzlo mari; T6 mem_read mdri; T7 mdro gra rin.
REQ-017 SHALL execute ST as LD T3-T5; T6 gra rout mdri; T7 mem_write.
REQ-018 SHALL execute BR as T3 gra rout conin; T4 pco ryi; T5 csigno rzli ADD; T6 rzlo, with pci = con_ff sampled in T6.
REQ-019 SHALL execute IN as T3 ipo gra rin, and OUT as T3 gra rout opi.
REQ-020 SHALL return NOP and any undefined opcode to T0 directly after T2.
REQ-021 SHALL enter HALTED from T3 on HALT; HALTED holds all outputs 0 and run 0 until clear.
REQ-022 SHALL sample stop only on the transition into T0: if stop=1, go to HALTED instead of T0; a stop pulse outside that cycle is ignored.
REQ-023 SHALL give instruction lengths in clocks: ALU/ADDI/LDI 6, LD/ST 8, BR 7, IN/OUT 4, NOP 3.

Reset
REQ-024 SHALL, while clear=1 at a rising edge, enter state RST with all outputs 0 and run 0, overriding any state including HALTED or mid-instruction.
REQ-025 SHALL move RST to T0 on the first edge with clear=0, with run=1 from T0 onward.

Structure
REQ-026 SHALL place opcode constants, state encoding and alu_op codes (ADD 0, SUB 1, AND 2, OR 3) in shared package cpu_ctrl_pkg.
REQ-027 SHALL factor opcode-to-instruction-class mapping into sub-module opcode_decode (combinational).

Verification
REQ-028 SHALL cover reset then ir=32'h18918000 (add r1,r2,r3) -> T0..T5 sequence per REQ-010/013, alu_op=0 in T4, gra+rin in T5, T0 again at clock 7.
REQ-029 SHALL cover LD ir=32'h00800055 -> mem_read+mdri in T1 and T6, mdro+gra+rin in T7, 8-clock length.
REQ-030 SHALL cover BR with con_ff=1 and with con_ff=0 -> pci=1 in T6 only when con_ff=1.
REQ-031 SHALL cover stop=1 during an ST T5 -> ST completes mem_write in T7, then HALTED, run=0, no further pco.
REQ-032 SHALL cover clear asserted in LD T6 -> next cycle RST, all outputs 0, T0 one clock after clear drops.
REQ-033 SHALL cover opcode 11111 -> T0 after T2, no writes (rin, mem_write, pci in execute all 0).
